// File: rtl/out_stream_collector.sv
// Four-stream FIFO collector: round-robin arbiter feeding a nibble serialiser with running XOR parity.
// Optional OUT_TAG_EN: prefix every word with a {2'b10, stream_idx} tag nibble.
module out_stream_collector #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] C_out_0_din,
  input  logic              C_out_0_write,
  output logic              C_out_0_full_n,
  input  logic [DATA_W-1:0] C_out_1_din,
  input  logic              C_out_1_write,
  output logic              C_out_1_full_n,
  input  logic [DATA_W-1:0] C_out_2_din,
  input  logic              C_out_2_write,
  output logic              C_out_2_full_n,
  input  logic [DATA_W-1:0] C_out_3_din,
  input  logic              C_out_3_write,
  output logic              C_out_3_full_n,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic              probe_out,
  output logic [1:0]        dbg_state
);

  localparam int NIB   = DATA_W / 4;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_TAG   = 2'd2
  } state_t;

  logic [DATA_W-1:0] din [4];
  logic [3:0]        wr;

  assign din[0] = C_out_0_din;
  assign din[1] = C_out_1_din;
  assign din[2] = C_out_2_din;
  assign din[3] = C_out_3_din;
  assign wr     = {C_out_3_write, C_out_2_write, C_out_1_write, C_out_0_write};

  // Write handshake: a word is taken on a clock edge where write=1 and the
  // registered full_n=1; anything else is ignored. full_n never depends on a same-cycle pop.
  logic [DATA_W-1:0] mem_q [4][FIFO_DEPTH];
  logic [AW-1:0]     wptr_q [4];
  logic [AW-1:0]     wptr_d [4];
  logic [AW-1:0]     rptr_q [4];
  logic [AW-1:0]     rptr_d [4];
  logic [CW-1:0]     count_q [4];
  logic [CW-1:0]     count_d [4];
  logic [3:0]        full_n_q, full_n_d;
  logic [3:0]        push, pop, nonempty;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        out_q, out_d;
  logic              valid_q, valid_d;
  logic              probe_q, probe_d;
  logic [1:0]        rr_q, rr_d;

  logic              any_ne, found, grant, last;
  logic [1:0]        gidx, idx;
  logic [DATA_W-1:0] head_word;

  // Round-robin search starting at rr_q.
  always_comb begin
    for (int k = 0; k < 4; k++) nonempty[k] = (count_q[k] != '0);
    any_ne = |nonempty;
    gidx   = rr_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && nonempty[idx]) begin
        gidx  = idx;
        found = 1'b1;
      end
    end
    head_word = mem_q[gidx][rptr_q[gidx]];
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    probe_d = probe_q;
    rr_d    = rr_q;
    grant   = 1'b0;
    last    = (cnt_q == CNT_W'(NIB - 1));
    case (state_q)
      S_IDLE: begin
        if (any_ne) begin
          grant = 1'b1;
        end else begin
          out_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (any_ne) begin
            grant = 1'b1;
          end else begin
            state_d = S_IDLE;
            out_d   = '0;
            valid_d = 1'b0;
            shift_d = '0;
          end
        end else begin
          out_d   = shift_q[3:0];
          shift_d = shift_q >> 4;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef OUT_TAG_EN
      S_TAG: begin
        // Parity is applied here so it becomes visible with nibble 0, not the tag.
        out_d   = shift_q[3:0];
        shift_d = shift_q >> 4;
        cnt_d   = '0;
        state_d = S_SHIFT;
        probe_d = probe_q ^ (^shift_q);
      end
`endif
      default: begin
        state_d = S_IDLE;
        out_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    if (grant) begin
      rr_d    = gidx + 2'd1;
      valid_d = 1'b1;
      cnt_d   = '0;
`ifdef OUT_TAG_EN
      out_d   = {2'b10, gidx};
      shift_d = head_word;
      state_d = S_TAG;
`else
      out_d   = head_word[3:0];
      shift_d = head_word >> 4;
      state_d = S_SHIFT;
      probe_d = probe_q ^ (^head_word);
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      push[k]     = wr[k] && full_n_q[k];
      pop[k]      = grant && (gidx == 2'(k));
      count_d[k]  = count_q[k] + CW'(push[k]) - CW'(pop[k]);
      full_n_d[k] = (count_d[k] != CW'(FIFO_DEPTH));
      wptr_d[k]   = wptr_q[k] + AW'(push[k]);
      rptr_d[k]   = rptr_q[k] + AW'(pop[k]);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      probe_q  <= 1'b0;
      rr_q     <= '0;
      full_n_q <= 4'hF;
      for (int k = 0; k < 4; k++) begin
        wptr_q[k]  <= '0;
        rptr_q[k]  <= '0;
        count_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      probe_q  <= probe_d;
      rr_q     <= rr_d;
      full_n_q <= full_n_d;
      for (int k = 0; k < 4; k++) begin
        wptr_q[k]  <= wptr_d[k];
        rptr_q[k]  <= rptr_d[k];
        count_q[k] <= count_d[k];
      end
    end
  end

  // Storage needs no reset: occupancy lives in the pointers and counts.
  always_ff @(posedge ap_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k]) mem_q[k][wptr_q[k]] <= din[k];
    end
  end

  assign C_out_0_full_n = full_n_q[0];
  assign C_out_1_full_n = full_n_q[1];
  assign C_out_2_full_n = full_n_q[2];
  assign C_out_3_full_n = full_n_q[3];
  assign data_out       = out_q;
  assign data_valid     = valid_q;
  assign probe_out      = probe_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_out_stream_collector.sv
// Directed bench for out_stream_collector: per-cycle vector tables plus hand-written multi-cycle sequences.
module tb_out_stream_collector;

`ifdef OUT_TAG_EN
  localparam int TAGC = 1;
`else
  localparam int TAGC = 0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] din [4];
  logic [3:0]  wr;
  logic [3:0]  fn;
  logic [3:0]  data_out;
  logic        data_valid;
  logic        probe_out;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  wr;
    logic [31:0] din;
    logic        dv;
    logic [3:0]  dout;
    logic        probe;
    logic [3:0]  full_n;
  } vec_t;

  vec_t tbl[$];

  always #5 ap_clk = ~ap_clk;

  out_stream_collector #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .C_out_0_din(din[0]), .C_out_0_write(wr[0]), .C_out_0_full_n(fn[0]),
    .C_out_1_din(din[1]), .C_out_1_write(wr[1]), .C_out_1_full_n(fn[1]),
    .C_out_2_din(din[2]), .C_out_2_write(wr[2]), .C_out_2_full_n(fn[2]),
    .C_out_3_din(din[3]), .C_out_3_write(wr[3]), .C_out_3_full_n(fn[3]),
    .data_out(data_out), .data_valid(data_valid), .probe_out(probe_out),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] w, input logic [31:0] d, input logic dv,
                              input logic [3:0] o, input logic p, input logic [3:0] f);
    vec_t v;
    v.wr = w; v.din = d; v.dv = dv; v.dout = o; v.probe = p; v.full_n = f;
    return v;
  endfunction

  task automatic clear_inputs();
    wr = '0;
    for (int k = 0; k < 4; k++) din[k] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ap_rst_n = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  // Each row: drive inputs for this cycle, compare the registered outputs of this cycle, advance.
  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      wr = tbl[i].wr;
      for (int k = 0; k < 4; k++) din[k] = tbl[i].din;
      chk($sformatf("%s[%0d].dv", nm, i), 32'(data_valid), 32'(tbl[i].dv));
      chk($sformatf("%s[%0d].dout", nm, i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("%s[%0d].probe", nm, i), 32'(probe_out), 32'(tbl[i].probe));
      chk($sformatf("%s[%0d].full_n", nm, i), 32'(fn), 32'(tbl[i].full_n));
      tick();
    end
    clear_inputs();
  endtask

  // Reads one emitted word; returns in the cycle after its last nibble.
  task automatic get_word(input string nm, input bit immediate,
                          output logic [31:0] w, output logic [1:0] tg);
    int n;
    n  = 0;
    w  = '0;
    tg = '0;
    while (data_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (immediate) chk({nm, ".bubble"}, n, 0);
    if (data_valid !== 1'b1) begin
      chk({nm, ".timeout"}, 32'(data_valid), 32'd1);
      return;
    end
`ifdef OUT_TAG_EN
    chk({nm, ".tag_hi"}, 32'(data_out[3:2]), 32'd2);
    tg = data_out[1:0];
    tick();
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.contig%0d", nm, i), 32'(data_valid), 32'd1);
      w[4*i +: 4] = data_out;
      tick();
    end
  endtask

  logic [31:0] w;
  logic [1:0]  tg;
  int          n0, n1, quiet;

  initial begin
    clear_inputs();
    ap_rst_n = 1'b0;
    tick();
    chk("rst.dv", 32'(data_valid), 32'd0);
    chk("rst.dout", 32'(data_out), 32'd0);
    chk("rst.probe", 32'(probe_out), 32'd0);
    chk("rst.full_n", 32'(fn), 32'hF);
    chk("rst.state", 32'(dbg_state), 32'd0);
    ap_rst_n = 1'b1;
    tick();

`ifndef OUT_TAG_EN
    // Single word on stream 0: nibbles LSB first at t+2..t+9.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4'h1, 32'h12345678, 0, 4'h0, 0, 4'hF));
    tbl.push_back(mk(4'h0, 32'h0, 0, 4'h0, 0, 4'hF));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(4'h0, 32'h0, 1, 4'(8 - i), 1, 4'hF));
    tbl.push_back(mk(4'h0, 32'h0, 0, 4'h0, 1, 4'hF));
    run_table("single");

    // Stream 2 overflow: word 6 arrives while full_n=0 and is dropped.
    do_reset();
    tbl.delete();
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(4'h4, 32'(i + 1), (i >= 2), (i == 2) ? 4'h1 : 4'h0,
                       (i >= 2), (i == 5) ? 4'hB : 4'hF));
    for (int i = 6; i < 10; i++) tbl.push_back(mk(4'h0, 32'h0, 1, 4'h0, 1, 4'hB));
    tbl.push_back(mk(4'h0, 32'h0, 1, 4'h2, 0, 4'hF));
    for (int i = 11; i < 18; i++) tbl.push_back(mk(4'h0, 32'h0, 1, 4'h0, 0, 4'hF));
    run_table("ovf");
    for (int j = 3; j <= 5; j++) begin
      get_word($sformatf("ovf.w%0d", j), 1'b1, w, tg);
      chk($sformatf("ovf.word%0d", j), w, 32'(j));
    end
    chk("ovf.probe_end", 32'(probe_out), 32'd1);
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      if (data_valid === 1'b1) quiet++;
      tick();
    end
    chk("ovf.dropped", quiet, 0);
`else
    // Tag nibble 0xB for stream 3, then eight 0xF; parity of all-ones is 0.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4'h8, 32'hFFFFFFFF, 0, 4'h0, 0, 4'hF));
    tbl.push_back(mk(4'h0, 32'h0, 0, 4'h0, 0, 4'hF));
    tbl.push_back(mk(4'h0, 32'h0, 1, 4'hB, 0, 4'hF));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(4'h0, 32'h0, 1, 4'hF, 0, 4'hF));
    tbl.push_back(mk(4'h0, 32'h0, 0, 4'h0, 0, 4'hF));
    run_table("tag");
`endif

    // All four streams at once: served 0,1,2,3 back to back.
    do_reset();
    wr = 4'hF;
    for (int k = 0; k < 4; k++) din[k] = 32'hA0000000 + 32'(k);
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      get_word($sformatf("rr4.w%0d", k), (k > 0), w, tg);
      chk($sformatf("rr4.word%0d", k), w, 32'hA0000000 + 32'(k));
`ifdef OUT_TAG_EN
      chk($sformatf("rr4.tag%0d", k), 32'(tg), 32'(k));
`endif
    end
    chk("rr4.idle_after", 32'(data_valid), 32'd0);
    chk("rr4.probe_end", 32'(probe_out), 32'd0);

    // Streams 0 and 1 kept backlogged: grants must alternate.
    do_reset();
    n0 = 0;
    n1 = 0;
    fork
      begin
        for (int c = 0; c < 200 && (n0 < 6 || n1 < 6); c++) begin
          wr[0]  = (n0 < 6) && fn[0];
          din[0] = 32'h01000000 + 32'(n0);
          if (wr[0]) n0++;
          wr[1]  = (n1 < 6) && fn[1];
          din[1] = 32'h02000000 + 32'(n1);
          if (wr[1]) n1++;
          tick();
        end
        wr[0] = 1'b0;
        wr[1] = 1'b0;
      end
      begin
        for (int j = 0; j < 12; j++) begin
          get_word($sformatf("alt.w%0d", j), (j > 0), w, tg);
          chk($sformatf("alt.word%0d", j), w,
              ((j % 2 == 0) ? 32'h01000000 : 32'h02000000) + 32'(j / 2));
        end
      end
    join
    chk("alt.idle_after", 32'(data_valid), 32'd0);

    // Asynchronous reset in the middle of a word.
    do_reset();
    wr[1]  = 1'b1;
    din[1] = 32'h87654321;
    tick();
    wr[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr[3]  = 1'b1;
      din[3] = 32'h30 + 32'(i);
      tick();
    end
    clear_inputs();
    for (int i = 0; i < TAGC; i++) tick();
    chk("arst.pre_dv", 32'(data_valid), 32'd1);
    chk("arst.pre_nib3", 32'(data_out), 32'h4);
    chk("arst.pre_probe", 32'(probe_out), 32'd1);
    chk("arst.pre_full_n", 32'(fn), 32'h7);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst.dv", 32'(data_valid), 32'd0);
    chk("arst.dout", 32'(data_out), 32'd0);
    chk("arst.probe", 32'(probe_out), 32'd0);
    chk("arst.full_n", 32'(fn), 32'hF);
    tick();
    ap_rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (data_valid === 1'b1) quiet++;
    end
    chk("arst.no_residue", quiet, 0);
    wr[2]  = 1'b1;
    din[2] = 32'h00000007;
    tick();
    clear_inputs();
    get_word("arst.next", 1'b0, w, tg);
    chk("arst.next_word", w, 32'h00000007);
    chk("arst.next_probe", 32'(probe_out), 32'd1);
    chk("arst.next_idle", 32'(data_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
